// File: rtl/grf_mp_sb_if.sv
// Register-file bus: read ports, two write ports, reserve port and scoreboard status.
interface grf_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] ra;
    logic [NREAD*DATA_W-1:0] rd;
    logic [NREAD-1:0]        r_pend;
    logic                    we0;
    logic [ADDR_W-1:0]       wa0;
    logic [DATA_W-1:0]       wd0;
    logic                    we1;
    logic [ADDR_W-1:0]       wa1;
    logic [DATA_W-1:0]       wd1;
    logic                    rsv_en;
    logic [ADDR_W-1:0]       rsv_a;
    logic                    any_pend;
    logic [ADDR_W:0]         pend_cnt;

    // Pipeline side: issues reads, writes and reservations.
    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_a,
        input  rd, r_pend, any_pend, pend_cnt
    );

    // Register file side.
    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_a,
        output rd, r_pend, any_pend, pend_cnt
    );
endinterface

// File: rtl/grf_mp_sb.sv
// General register file: NREAD bypassed read ports, W-stage write port 0,
// late (mult/div) write port 1, and a per-register pending scoreboard.
module grf_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         reset,
    grf_mp_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]        pend;
    logic [DEPTH-1:0]        pend_next;
    logic [ADDR_W:0]         cnt_next;
    logic [ADDR_W:0]         pend_cnt_q;
    logic                    any_pend_q;
    logic [NREAD*DATA_W-1:0] rd_v;
    logic [NREAD-1:0]        rpend_v;

    // Writes to register 0 vanish when it is hardwired to zero.
    logic drop0, drop1;
    assign drop0 = ZR && (bus.wa0 == '0);
    assign drop1 = ZR && (bus.wa1 == '0);

    // Bypassed read of one address: zero reg, then port 0, then port 1, then array.
    function automatic logic [DATA_W-1:0] read_data(input logic [ADDR_W-1:0] a);
        if (ZR && a == '0)                       return '0;
        else if (bus.we0 && !drop0 && bus.wa0 == a) return bus.wd0;
        else if (bus.we1 && !drop1 && bus.wa1 == a) return bus.wd1;
        else                                     return mem[a];
    endfunction

    // Array commit; port 0 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        // NOTE: the array is reset on purpose - every register must read 0 after reset.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            // NOTE: non-blocking writes here; the later one to the same entry wins.
            if (bus.we1 && !drop1) mem[bus.wa1] <= bus.wd1;
            if (bus.we0 && !drop0) mem[bus.wa0] <= bus.wd0;
        end
    end

    // Next scoreboard: a new reservation beats a same-cycle port-1 retire.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch.
        pend_next = '0;
        cnt_next  = '0;
        for (int a = 0; a < DEPTH; a++) begin
            pend_next[a] = (bus.rsv_en && bus.rsv_a == ADDR_W'(a) && !(ZR && a == 0))
                         | (pend[a] && !(bus.we1 && bus.wa1 == ADDR_W'(a)));
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, pend_next[a]};
        end
    end

    // Scoreboard and its registered summary (count / any) update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend       <= '0;
            pend_cnt_q <= '0;
            any_pend_q <= 1'b0;
        end else begin
            pend       <= pend_next;
            pend_cnt_q <= cnt_next;
            any_pend_q <= |pend_next;
        end
    end

    // Read ports; an arriving port-1 result masks its own pending bit.
    always_comb begin
        rd_v    = '0;
        rpend_v = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_v[i*DATA_W +: DATA_W] = read_data(bus.ra[i*ADDR_W +: ADDR_W]);
            rpend_v[i] = pend[bus.ra[i*ADDR_W +: ADDR_W]]
                       && !(bus.we1 && bus.wa1 == bus.ra[i*ADDR_W +: ADDR_W]);
        end
    end

    assign bus.rd       = rd_v;
    assign bus.r_pend   = rpend_v;
    assign bus.pend_cnt = pend_cnt_q;
    assign bus.any_pend = any_pend_q;
endmodule

// File: tb/tb_grf_mp_sb.sv
// Directed, table-driven bench for grf_mp_sb (two read ports, 32x32, zero reg).
module tb_grf_mp_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;

    typedef struct {
        logic        we0;  logic [4:0] wa0;  logic [31:0] wd0;
        logic        we1;  logic [4:0] wa1;  logic [31:0] wd1;
        logic        rsv_en; logic [4:0] rsv_a;
        logic [4:0]  ra0;  logic [4:0] ra1;
        logic [31:0] e_rd0; logic [31:0] e_rd1;  // before the edge
        logic [1:0]  e_rp;                        // before the edge
        logic [5:0]  e_cnt;                       // after the edge
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    vec_t vq[$];

    grf_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus ();

    grf_mp_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we0 = 0; bus.wa0 = 0; bus.wd0 = 0;
        bus.we1 = 0; bus.wa1 = 0; bus.wd1 = 0;
        bus.rsv_en = 0; bus.rsv_a = 0;
    endtask

    task automatic add(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic rsv_en, input logic [4:0] rsv_a,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                       input logic [1:0] e_rp, input logic [5:0] e_cnt);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.rsv_en = rsv_en; v.rsv_a = rsv_a;
        v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rp = e_rp; v.e_cnt = e_cnt;
        vq.push_back(v);
    endtask

    initial begin
        //   we0 wa0 wd0            we1 wa1 wd1      rsv  a   ra0 ra1  e_rd0          e_rd1          rp     cnt
        add(0, 0,  0,            0, 0,  0,       0, 0,  3,  0,  32'h0,         32'h0,         2'b00, 0); // 0 idle after reset
        add(1, 8,  32'h12345678, 0, 0,  0,       0, 0,  8,  0,  32'h12345678,  32'h0,         2'b00, 0); // 1 write bypass
        add(0, 0,  0,            0, 0,  0,       0, 0,  8,  0,  32'h12345678,  32'h0,         2'b00, 0); // 2 committed
        add(1, 0,  32'hFFFFFFFF, 0, 0,  0,       0, 0,  0,  8,  32'h0,         32'h12345678,  2'b00, 0); // 3 zero-reg write
        add(0, 0,  0,            0, 0,  0,       1, 0,  0,  0,  32'h0,         32'h0,         2'b00, 0); // 4 reserve reg 0 ignored
        add(0, 0,  0,            0, 0,  0,       1, 9,  9,  0,  32'h0,         32'h0,         2'b00, 1); // 5 reserve 9, not yet visible
        add(0, 0,  0,            0, 0,  0,       0, 0,  9,  0,  32'h0,         32'h0,         2'b01, 1); // 6 idle
        add(0, 0,  0,            0, 0,  0,       0, 0,  9,  0,  32'h0,         32'h0,         2'b01, 1); // 7 idle
        add(0, 0,  0,            0, 0,  0,       0, 0,  0,  9,  32'h0,         32'h0,         2'b10, 1); // 8 idle
        add(0, 0,  0,            1, 9,  32'hABCD,0, 0,  9,  9,  32'hABCD,      32'hABCD,      2'b00, 0); // 9 late result
        add(0, 0,  0,            0, 0,  0,       0, 0,  9,  0,  32'hABCD,      32'h0,         2'b00, 0); // 10
        add(1, 4,  32'h11,       1, 4,  32'h22,  0, 0,  4,  0,  32'h11,        32'h0,         2'b00, 0); // 11 dual write
        add(0, 0,  0,            0, 0,  0,       0, 0,  4,  0,  32'h11,        32'h0,         2'b00, 0); // 12
        add(0, 0,  0,            1, 4,  32'h33,  1, 4,  4,  0,  32'h33,        32'h0,         2'b00, 1); // 13 reserve beats clear
        add(0, 0,  0,            0, 0,  0,       0, 0,  4,  9,  32'h33,        32'hABCD,      2'b01, 1); // 14
        add(0, 0,  0,            1, 4,  32'h44,  0, 0,  4,  0,  32'h44,        32'h0,         2'b00, 0); // 15 retire 4
        add(0, 0,  0,            0, 0,  0,       1, 31, 0,  31, 32'h0,         32'h0,         2'b00, 1); // 16 reserve top reg
        add(1, 31, 32'h55,       0, 0,  0,       0, 0,  0,  31, 32'h0,         32'h55,        2'b10, 1); // 17 port 0 keeps pend
        add(0, 0,  0,            1, 31, 32'h66,  0, 0,  0,  31, 32'h0,         32'h66,        2'b00, 0); // 18 retire 31
        add(0, 0,  0,            0, 0,  0,       1, 7,  7,  0,  32'h0,         32'h0,         2'b00, 1); // 19 reserve 7
        add(0, 0,  0,            0, 0,  0,       1, 7,  7,  0,  32'h0,         32'h0,         2'b01, 1); // 20 re-reserve no nesting
        add(0, 0,  0,            1, 7,  32'h77,  0, 0,  7,  0,  32'h77,        32'h0,         2'b00, 0); // 21 single retire clears

        bus.ra = '0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset pend_cnt", 64'(bus.pend_cnt), 64'd0);
        check("reset any_pend", 64'(bus.any_pend), 64'd0);

        for (int i = 0; i < vq.size(); i++) begin
            bus.we0 = vq[i].we0; bus.wa0 = vq[i].wa0; bus.wd0 = vq[i].wd0;
            bus.we1 = vq[i].we1; bus.wa1 = vq[i].wa1; bus.wd1 = vq[i].wd1;
            bus.rsv_en = vq[i].rsv_en; bus.rsv_a = vq[i].rsv_a;
            bus.ra = {vq[i].ra1, vq[i].ra0};
            #1;
            check($sformatf("v%0d rd0", i), 64'(bus.rd[31:0]),  64'(vq[i].e_rd0));
            check($sformatf("v%0d rd1", i), 64'(bus.rd[63:32]), 64'(vq[i].e_rd1));
            check($sformatf("v%0d r_pend", i), 64'(bus.r_pend), 64'(vq[i].e_rp));
            tick();
            check($sformatf("v%0d pend_cnt", i), 64'(bus.pend_cnt), 64'(vq[i].e_cnt));
            check($sformatf("v%0d any_pend", i), 64'(bus.any_pend), 64'(vq[i].e_cnt != 0));
        end

        // Reserve 5, 6, 7 then reset while a write and reserve are also requested.
        idle_inputs();
        for (int r = 5; r <= 7; r++) begin
            bus.rsv_en = 1; bus.rsv_a = 5'(r);
            tick();
        end
        idle_inputs();
        bus.ra = {5'd6, 5'd5};
        #1;
        check("pre-reset pend_cnt", 64'(bus.pend_cnt), 64'd3);
        check("pre-reset r_pend", 64'(bus.r_pend), 64'b11);
        reset = 1'b1;
        bus.we0 = 1; bus.wa0 = 5; bus.wd0 = 32'h99;
        bus.rsv_en = 1; bus.rsv_a = 8;
        tick();
        reset = 1'b0;
        idle_inputs();
        bus.ra = {5'd8, 5'd5};
        #1;
        check("mid-reset pend_cnt", 64'(bus.pend_cnt), 64'd0);
        check("mid-reset any_pend", 64'(bus.any_pend), 64'd0);
        check("mid-reset rd reg5", 64'(bus.rd[31:0]), 64'd0);
        check("mid-reset rd reg8", 64'(bus.rd[63:32]), 64'd0);
        check("mid-reset r_pend", 64'(bus.r_pend), 64'd0);
        tick();
        check("post-reset pend_cnt", 64'(bus.pend_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/grf_mp_sb.md
Name: grf_mp_sb

Overview:
- Parametrised general register file for the pipelined CPU. Successor to the single-write, two-read GRF.
- Provides NREAD read ports with same-cycle write bypass, and two write ports:
  - port 0: W-stage writeback.
  - port 1: late writeback from multi-cycle units such as mult/div.
- A per-register pending scoreboard lets the hazard unit stall readers of registers whose multi-cycle result has not yet arrived.
- Sits in D stage; written from W stage and from the multi-cycle unit.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NREAD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
ra  input  NREAD*ADDR_W  read addresses; port i = ra[i*ADDR_W +: ADDR_W]
rd  output  NREAD*DATA_W  read data; port i = rd[i*DATA_W +: DATA_W]
r_pend  output  NREAD  port i address has an outstanding reservation
we0  input  1  write enable, port 0
wa0  input  ADDR_W  write address, port 0
wd0  input  DATA_W  write data, port 0
we1  input  1  write enable, port 1; also retires the reservation
wa1  input  ADDR_W  write address, port 1
wd1  input  DATA_W  write data, port 1
rsv_en  input  1  reserve destination register (multi-cycle op issued)
rsv_a  input  ADDR_W  register to reserve
any_pend  output  1  OR of all scoreboard bits
pend_cnt  output  ADDR_W+1  number of pending registers

Behaviour:
- Reset (clk edge with reset=1):
  - All registers and all scoreboard bits cleared.
  - pend_cnt=0 and any_pend=0 from the following cycle.
  - rd reads 0 unless bypassed; r_pend=0.
  - Reset overrides any concurrent write or reserve, including mid-operation.
- Write commit:
  - Data is written into the array on the posedge where weN=1.
  - If ZERO_REG=1 and waN==0, the write is dropped.
- Dual write, same address, same cycle: port 0 value is committed, port 1 value is discarded. Port 1 still clears the pending bit.
- Read is combinational. Priority for port i:
  1. ZERO_REG && ra_i==0 -> 0.
  2. we0 && wa0==ra_i && wa0 not dropped -> wd0.
  3. we1 && wa1==ra_i && wa1 not dropped -> wd1.
  4. Otherwise the array value.
  Write-then-read therefore has 0-cycle visible latency.
- Scoreboard update per posedge, for address a:
  - next[a] = (rsv_en && rsv_a==a) | (pend[a] && !(we1 && wa1==a)).
  - Reserve and clear of the same address in one cycle: reserve wins, bit stays 1 (a new op was issued).
  - Reserving an already-pending register leaves it set; no counting or nesting.
  - ZERO_REG=1: reserve of register 0 is ignored.
  - Port 0 writes never affect the scoreboard.
- r_pend[i] = pend[ra_i] && !(we1 && wa1==ra_i). The arriving result is bypassed in the same cycle, so no stall is needed.
  - A reservation becomes visible on r_pend the cycle after rsv_en.
- pend_cnt / any_pend:
  - Both are registered and reflect the scoreboard after the most recent edge.
  - pend_cnt is the population count, range 0..2**ADDR_W.
- Widths: no arithmetic on data; addresses compare over the full ADDR_W bits.

Test Plan:
- Reset, then read ra={5'd3,5'd0} -> rd both 0, r_pend=0, pend_cnt=0.
- we0=1, wa0=8, wd0=32'h1234_5678, ra port0=8, same cycle -> rd0=32'h12345678. Next cycle with we0=0 -> still 32'h12345678.
- Write to register 0:
  - ZERO_REG=1: we0=1, wa0=0, wd0=32'hFFFF_FFFF -> rd for ra=0 is 0, both during the write cycle and after.
  - rsv_en with rsv_a=0 -> pend_cnt stays 0.
- Scoreboard sequence:
  - rsv_en, rsv_a=9 -> next cycle r_pend=1 for ra=9, pend_cnt=1, any_pend=1.
  - Three idle cycles -> unchanged.
  - we1=1, wa1=9, wd1=32'hABCD -> same cycle r_pend=0, rd=32'hABCD.
  - Next cycle pend_cnt=0.
- Simultaneous events:
  - we0 and we1 both to address 4 with wd0=32'h11, wd1=32'h22 -> read returns 32'h11 that cycle and after.
  - Same cycle rsv_en, rsv_a=4 with we1 wa1=4 -> bit 4 pending next cycle.
- Reset mid-operation: reserve registers 5, 6, 7 (pend_cnt=3), and in the reset cycle assert we0 wa0=5 -> next cycle pend_cnt=0, register 5 reads 0.
